mem_bus_master: RTL and testbench

- Initiator side of the processor's word-addressed memory bus.
- Accepts one load/store request at a time from the core (byte, half or word, signed or unsigned loads).
- Drives the rd_en/wr_en/addr/data bus and waits for the responder's ack.
- Sub-word stores are done as read-modify-write, because the memory writes whole 32-bit words only.
- Returns load data, sign- or zero-extended, plus an error flag for misalignment or ack timeout.

---
 rtl/mem_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Initiator for the word-addressed memory bus: one load/store at a time,
// sub-word stores via read-modify-write, ack timeout and misalignment errors.
module mem_bus_master #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [1:0]         r_lane;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic               w_bad_req;
    logic               w_accept;

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                  input logic [1:0]  size,
                                                  input logic [1:0]  lane,
                                                  input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Overlay right-aligned store data onto the addressed lane(s) of the old word.
    function automatic logic [31:0] f_store_merge(input logic [31:0] word,
                                                  input logic [31:0] wdata,
                                                  input logic [1:0]  size,
                                                  input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        case (size)
            2'b00: m[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) m[31:16] = wdata[15:0];
                else         m[15:0]  = wdata[15:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CNT_W'(ACK_TIMEOUT));
    assign w_accept  = req_valid_i && req_ready_o;
    assign w_bad_req = (req_size_i == 2'b11) ||
                       ((req_size_i == 2'b01) && req_addr_i[0]) ||
                       ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= 32'b0;
            r_cnt        <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= 32'b0;
            mem_rd_en_o  <= 1'b0;
            mem_wr_en_o  <= 1'b0;
            mem_addr_o   <= 32'b0;
            mem_data_o   <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size      <= req_size_i;
                        r_uns       <= req_unsigned_i;
                        r_lane      <= req_addr_i[1:0];
                        r_wdata     <= req_wdata_i;
                        r_cnt       <= '0;
                        req_ready_o <= 1'b0;
                        mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                        if (w_bad_req) begin
                            r_state      <= S_RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= 32'b0;
                        end else if (!req_we_i) begin
                            r_state     <= S_READ;
                            mem_rd_en_o <= 1'b1;
                        end else if (req_size_i == 2'b10) begin
                            r_state     <= S_WRITE;
                            mem_wr_en_o <= 1'b1;
                            mem_data_o  <= req_wdata_i;
                        end else begin
                            r_state     <= S_RMW_READ;
                            mem_rd_en_o <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    if (mem_ack_i) begin
                        mem_rd_en_o  <= 1'b0;
                        r_state      <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= f_load_extend(mem_data_i, r_size, r_lane, r_uns);
                    end else if (w_timeout) begin
                        mem_rd_en_o  <= 1'b0;
                        r_state      <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'b0;
                        r_cnt        <= w_cnt_inc;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                // Read half of the RMW: the write enable replaces the read enable on the same edge.
                S_RMW_READ: begin
                    if (mem_ack_i) begin
                        mem_rd_en_o <= 1'b0;
                        mem_wr_en_o <= 1'b1;
                        mem_data_o  <= f_store_merge(mem_data_i, r_wdata, r_size, r_lane);
                        r_cnt       <= '0;
                        r_state     <= S_WRITE;
                    end else if (w_timeout) begin
                        mem_rd_en_o  <= 1'b0;
                        r_state      <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'b0;
                        r_cnt        <= w_cnt_inc;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_WRITE: begin
                    if (mem_ack_i || w_timeout) begin
                        mem_wr_en_o  <= 1'b0;
                        r_state      <= S_RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= !mem_ack_i;
                        resp_rdata_o <= 32'b0;
                    end
                    if (!mem_ack_i) begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                S_RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= 32'b0;
                    req_ready_o  <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    mem_rd_en_o  <= 1'b0;
                    mem_wr_en_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a behavioural memory responder.
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    mem_bus_master #(.ACK_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          ack_wait = 0;
    bit          ack_en = 1'b1;
    int          en_cnt = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          both_hi = 0;
    int          resp_cnt = 0;
    logic [31:0] last_addr = 32'b0;
    logic [31:0] last_wdata = 32'b0;
    logic [31:0] mem [0:63];

    // Responder: ack arrives once the enable has been held ack_wait+1 cycles.
    always @(negedge clk) begin
        if (mem_rd_en_o) rd_cycles++;
        if (mem_wr_en_o) begin
            wr_cycles++;
            last_wdata = mem_data_o;
        end
        if (mem_rd_en_o && mem_wr_en_o) both_hi++;
        if (mem_rd_en_o || mem_wr_en_o) last_addr = mem_addr_o;
        if (resp_valid_o) resp_cnt++;
        mem_ack_i  = (mem_rd_en_o || mem_wr_en_o) && ack_en && (en_cnt == ack_wait);
        mem_data_i = mem[mem_addr_o[7:2]];
    end

    always @(posedge clk) begin
        if (mem_rd_en_o || mem_wr_en_o) begin
            if (mem_ack_i) begin
                en_cnt <= 0;
                if (mem_wr_en_o) mem[mem_addr_o[7:2]] <= mem_data_o;
            end else begin
                en_cnt <= en_cnt + 1;
            end
        end else begin
            en_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nrd, output int nwr);
        int n;
        int s_rd;
        int s_wr;
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_wait", 32'(req_ready_o), 32'd1);
        s_rd = rd_cycles;
        s_wr = wr_cycles;
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid_o && lat < 100);
        if (lat >= 100) chk("resp_wait", 32'(resp_valid_o), 32'd1);
        rdata = resp_rdata_o;
        err   = resp_err_o;
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid_o), 32'd0);
        chk("ready_after_resp", 32'(req_ready_o), 32'd1);
        nrd = rd_cycles - s_rd;
        nwr = wr_cycles - s_wr;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrd;
    int          nwr;
    int          s_resp;
    int          s_wr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_we_i = 1'b0;
        req_size_i = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i = 32'b0;
        req_wdata_i = 32'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en_o), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_data", mem_data_o, 32'd0);
        rst = 1'b0;

        // Preload through the DUT with word stores.
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, rd, er, lat, nrd, nwr);
        chk("wst_err", 32'(er), 32'd0);
        chk("wst_lat", 32'(lat), 32'd2);
        chk("wst_wr_cycles", 32'(nwr), 32'd1);
        chk("wst_rd_cycles", 32'(nrd), 32'd0);
        chk("wst_data", last_wdata, 32'h8899AABB);
        chk("wst_mem", mem[4], 32'h8899AABB);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat, nrd, nwr);
        chk("wst2_mem", mem[8], 32'h11223344);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("wld_rdata", rd, 32'h8899AABB);
        chk("wld_err", 32'(er), 32'd0);
        chk("wld_lat", 32'(lat), 32'd2);
        chk("wld_rd_cycles", 32'(nrd), 32'd1);
        chk("wld_addr", last_addr, 32'h10);

        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_signed", rd, 32'hFFFFFF99);
        chk("lb_addr", last_addr, 32'h10);
        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
        chk("lbu", rd, 32'h00000099);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, er, lat, nrd, nwr);
        chk("lh_signed", rd, 32'hFFFF8899);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, nrd, nwr);
        chk("lbu_lane3", rd, 32'h00000088);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("lhu_low", rd, 32'h0000AABB);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_signed_lane0", rd, 32'hFFFFFFBB);

        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB, rd, er, lat, nrd, nwr);
        chk("sb_err", 32'(er), 32'd0);
        chk("sb_rdata", rd, 32'd0);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_rd_cycles", 32'(nrd), 32'd1);
        chk("sb_wr_cycles", 32'(nwr), 32'd1);
        chk("sb_addr", last_addr, 32'h20);
        chk("sb_merged", last_wdata, 32'h1122AB44);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr);
        chk("sb_readback", rd, 32'h1122AB44);

        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, rd, er, lat, nrd, nwr);
        chk("sh_merged", last_wdata, 32'hBEEFAB44);
        chk("sh_mem", mem[8], 32'hBEEFAB44);

        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rd, er, lat, nrd, nwr);
        chk("mis_lw_err", 32'(er), 32'd1);
        chk("mis_lw_lat", 32'(lat), 32'd1);
        chk("mis_lw_rdata", rd, 32'd0);
        chk("mis_lw_bus", 32'(nrd + nwr), 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'h00005555, rd, er, lat, nrd, nwr);
        chk("mis_sh_err", 32'(er), 32'd1);
        chk("mis_sh_bus", 32'(nrd + nwr), 32'd0);
        chk("mis_sh_mem", mem[8], 32'hBEEFAB44);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("bad_size_err", 32'(er), 32'd1);
        chk("bad_size_bus", 32'(nrd + nwr), 32'd0);

        ack_wait = 2;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        chk("dly_rd_cycles", 32'(nrd), 32'd3);
        chk("dly_lat", 32'(lat), 32'd4);
        chk("dly_rdata", rd, 32'h8899AABB);
        chk("dly_err", 32'(er), 32'd0);
        ack_wait = 0;

        ack_en = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat, nrd, nwr);
        chk("to_rd_cycles", 32'(nrd), 32'd16);
        chk("to_err", 32'(er), 32'd1);
        chk("to_rdata", rd, 32'd0);
        chk("to_lat", 32'(lat), 32'd17);
        ack_en = 1'b1;

        // Reset while the RMW read is still waiting for its ack.
        ack_wait = 5;
        @(negedge clk);
        s_resp = resp_cnt;
        s_wr   = wr_cycles;
        req_valid_i    = 1'b1;
        req_we_i       = 1'b1;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h20;
        req_wdata_i    = 32'h00000055;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rmw_rd_en", 32'(mem_rd_en_o), 32'd1);
        chk("rmw_ready_low", 32'(req_ready_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rd_en", 32'(mem_rd_en_o), 32'd0);
        chk("mid_rst_wr_en", 32'(mem_wr_en_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_valid", 32'(resp_valid_o), 32'd0);
        repeat (8) @(negedge clk);
        chk("mid_rst_no_resp", 32'(resp_cnt - s_resp), 32'd0);
        chk("mid_rst_no_write", 32'(wr_cycles - s_wr), 32'd0);
        chk("mid_rst_mem", mem[8], 32'hBEEFAB44);
        ack_wait = 0;
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr);
        chk("post_rst_load", rd, 32'hBEEFAB44);

        chk("enables_exclusive", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
